instr_mem_sync: RTL and testbench

Parametrised, synchronous-read instruction memory for the MIPS 32-bit datapath, replacing the fixed 59-word asynchronous ROM. It serves one fetch per cycle with one-cycle latency, stall hold, and out-of-range/misalignment fault reporting. It also provides a sequential program-load port with an auto-incrementing write pointer, so the test bench or a boot loader can fill the array at run time instead of relying on a hard-coded initial image. It sits between the PC register and the IF/ID pipeline register.

---
 rtl/instr_mem_sync.sv | 117 +++++++++++
 tb/tb_instr_mem_sync.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory with one-cycle fetch latency, stall hold,
// range/alignment fault reporting and a sequential program-load port.
module instr_mem_sync #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 32,
  parameter int BYTE_ADDR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fault,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_busy,
  output logic              load_done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [ADDR_W-1:0] idx;
  logic              misaligned;
  logic              in_range;
  logic              do_write;

  // Contents survive rst_n; only power-up clears them.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  // Range check uses the full-width index so high PC bits can never alias into the array.
  always_comb begin
    idx        = pc;
    misaligned = 1'b0;
    if (BYTE_ADDR != 0) begin
      idx        = {2'b00, pc[ADDR_W-1:2]};
      misaligned = (pc[1:0] != 2'b00);
    end
  end

  assign in_range = (idx < ADDR_W'(DEPTH));
  assign do_write = rst_n && (state == LOAD) && load_valid && !load_start;

  always_ff @(posedge clk) begin
    if (do_write) mem[ptr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      load_busy <= 1'b0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state     <= LOAD;
            ptr       <= '0;
            load_busy <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            ptr <= '0;
          end else if (load_valid) begin
            if (ptr == PTR_W'(DEPTH - 1)) begin
              state     <= IDLE;
              ptr       <= '0;
              load_busy <= 1'b0;
              load_done <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          ptr       <= '0;
          load_busy <= 1'b0;
        end
      endcase
    end
  end

  // Stall freezes the whole fetch result, including a fault or a stale valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else if (!stall) begin
      if ((state == IDLE) && fetch_req) begin
        instr_valid <= 1'b1;
        if (misaligned || !in_range) begin
          instr <= '0;
          fault <= 1'b1;
        end else begin
          instr <= mem[idx[PTR_W-1:0]];
          fault <= 1'b0;
        end
      end else begin
        instr_valid <= 1'b0;
        fault       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: reset, load/fetch, faults, stall,
// load restart and reset-abort, fetch blocked during load.
module tb_instr_mem_sync;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] pc;
  logic        stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fault;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_busy;
  logic        load_done;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;
  int done_base;

  instr_mem_sync #(
    .DATA_W(32), .DEPTH(64), .ADDR_W(32), .BYTE_ADDR(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc), .stall(stall),
    .instr(instr), .instr_valid(instr_valid), .fault(fault),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_busy(load_busy), .load_done(load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_done === 1'b1) done_pulses++;
  end

  // Advance one rising edge and settle just after it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    fetch_req  = 1'b1;
    pc         = 32'h0;
    stall      = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = 32'h0;

    applyStimulus();
    applyStimulus();
    checkOutput("reset_instr", instr, 32'h0);
    checkOutput("reset_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("reset_fault", {31'b0, fault}, 32'h0);
    checkOutput("reset_busy", {31'b0, load_busy}, 32'h0);
    checkOutput("reset_done", {31'b0, load_done}, 32'h0);

    rst_n     = 1'b1;
    fetch_req = 1'b1;
    pc        = 32'h8;
    applyStimulus();
    checkOutput("zero_mem_instr", instr, 32'h0);
    checkOutput("zero_mem_valid", {31'b0, instr_valid}, 32'h1);
    checkOutput("zero_mem_fault", {31'b0, fault}, 32'h0);

    $display("[TB] full program load");
    fetch_req  = 1'b0;
    load_start = 1'b1;
    applyStimulus();
    load_start = 1'b0;
    checkOutput("busy_after_start", {31'b0, load_busy}, 32'h1);
    done_base  = done_pulses;
    fetch_req  = 1'b1;
    pc         = 32'h0;
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h1000_0000 + i;
      if (i == 63) pc = 32'h0C;
      applyStimulus();
      checkOutput("fetch_in_load_valid", {31'b0, instr_valid}, 32'h0);
      checkOutput("load_done_timing", {31'b0, load_done}, (i == 63) ? 32'h1 : 32'h0);
      checkOutput("load_busy_timing", {31'b0, load_busy}, (i == 63) ? 32'h0 : 32'h1);
    end
    load_valid = 1'b0;
    applyStimulus();
    checkOutput("first_fetch_instr", instr, 32'h1000_0003);
    checkOutput("first_fetch_valid", {31'b0, instr_valid}, 32'h1);
    checkOutput("first_fetch_fault", {31'b0, fault}, 32'h0);
    checkOutput("done_single_pulse", done_pulses - done_base, 32'h1);

    $display("[TB] fault cases");
    pc = 32'h100;
    applyStimulus();
    checkOutput("oor_instr", instr, 32'h0);
    checkOutput("oor_fault", {31'b0, fault}, 32'h1);
    checkOutput("oor_valid", {31'b0, instr_valid}, 32'h1);
    pc = 32'hFC;
    applyStimulus();
    checkOutput("last_word_instr", instr, 32'h1000_003F);
    checkOutput("last_word_fault", {31'b0, fault}, 32'h0);
    pc = 32'h102;
    applyStimulus();
    checkOutput("misaligned_fault", {31'b0, fault}, 32'h1);
    checkOutput("misaligned_instr", instr, 32'h0);
    pc = 32'h4000_0000;
    applyStimulus();
    checkOutput("alias_fault", {31'b0, fault}, 32'h1);
    checkOutput("alias_instr", instr, 32'h0);
    pc = 32'h6;
    applyStimulus();
    checkOutput("misaligned_low_fault", {31'b0, fault}, 32'h1);

    pc = 32'h10;
    applyStimulus();
    fetch_req = 1'b0;
    applyStimulus();
    checkOutput("idle_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("idle_fault", {31'b0, fault}, 32'h0);
    checkOutput("idle_instr_hold", instr, 32'h1000_0004);

    $display("[TB] stall hold");
    fetch_req = 1'b1;
    pc        = 32'h4;
    applyStimulus();
    checkOutput("pre_stall_instr", instr, 32'h1000_0001);
    stall = 1'b1;
    pc    = 32'h8;
    for (int i = 0; i < 3; i++) begin
      fetch_req = (i != 1);
      applyStimulus();
      checkOutput("stall_instr", instr, 32'h1000_0001);
      checkOutput("stall_valid", {31'b0, instr_valid}, 32'h1);
    end
    stall     = 1'b0;
    fetch_req = 1'b1;
    applyStimulus();
    checkOutput("post_stall_instr", instr, 32'h1000_0002);
    checkOutput("post_stall_valid", {31'b0, instr_valid}, 32'h1);

    $display("[TB] load restart");
    fetch_req  = 1'b0;
    done_base  = done_pulses;
    load_start = 1'b1;
    applyStimulus();
    load_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h2000_0000 + i;
      applyStimulus();
    end
    load_valid = 1'b0;
    load_start = 1'b1;
    applyStimulus();
    load_start = 1'b0;
    checkOutput("restart_busy", {31'b0, load_busy}, 32'h1);
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h3000_0000 + i;
      applyStimulus();
    end
    load_valid = 1'b0;
    applyStimulus();
    checkOutput("restart_done_once", done_pulses - done_base, 32'h1);
    fetch_req = 1'b1;
    pc        = 32'h0;
    applyStimulus();
    checkOutput("restart_word0", instr, 32'h3000_0000);
    pc = 32'h24;
    applyStimulus();
    checkOutput("restart_word9", instr, 32'h3000_0009);
    pc = 32'hFC;
    applyStimulus();
    checkOutput("restart_word63", instr, 32'h3000_003F);

    $display("[TB] reset abort");
    fetch_req  = 1'b0;
    done_base  = done_pulses;
    load_start = 1'b1;
    applyStimulus();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h5000_0000 + i;
      applyStimulus();
    end
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    applyStimulus();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h4000_0000 + i;
      applyStimulus();
    end
    load_valid = 1'b0;
    rst_n      = 1'b0;
    applyStimulus();
    checkOutput("abort_busy", {31'b0, load_busy}, 32'h0);
    checkOutput("abort_done", {31'b0, load_done}, 32'h0);
    rst_n     = 1'b1;
    fetch_req = 1'b1;
    pc        = 32'h0;
    applyStimulus();
    checkOutput("abort_word0", instr, 32'h4000_0000);
    checkOutput("abort_fetch_valid", {31'b0, instr_valid}, 32'h1);
    pc = 32'h10;
    applyStimulus();
    checkOutput("abort_word4", instr, 32'h4000_0004);
    pc = 32'h14;
    applyStimulus();
    checkOutput("abort_word5_old", instr, 32'h3000_0005);
    fetch_req = 1'b0;
    applyStimulus();
    checkOutput("abort_no_done", done_pulses - done_base, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
